// File: rtl/halfword_store_buffer_pkg.sv
// -----------------------------------------------------------------------------
// halfword_store_buffer_pkg
// Shared definitions for the halfword store buffer:
//   - entry field widths (data, halfword enables, byte enables)
//   - issue FSM state encoding (SB_IDLE, SB_REQ)
//   - halfword-enable to byte-enable expansion and halfword merge helpers
// Optional feature macro used by the top level: STORE_MERGE_EN.
// -----------------------------------------------------------------------------
package halfword_store_buffer_pkg;

  localparam int DATA_W = 32;  // replicated store data
  localparam int EN_W   = 2;   // one enable per halfword
  localparam int BE_W   = 4;   // one enable per byte

  typedef enum logic [0:0] {
    SB_IDLE = 1'b0,
    SB_REQ  = 1'b1
  } sb_state_e;

  // Each halfword enable covers the two bytes of that halfword.
  function automatic logic [BE_W-1:0] expand_be(input logic [EN_W-1:0] en);
    return {en[1], en[1], en[0], en[0]};
  endfunction

  // Enabled halfwords of new_d replace the matching halfwords of old_d.
  function automatic logic [DATA_W-1:0] merge_halves(input logic [DATA_W-1:0] old_d,
                                                     input logic [DATA_W-1:0] new_d,
                                                     input logic [EN_W-1:0]   en);
    logic [DATA_W-1:0] res;
    res[31:16] = en[1] ? new_d[31:16] : old_d[31:16];
    res[15:0]  = en[0] ? new_d[15:0]  : old_d[15:0];
    return res;
  endfunction

endpackage

// File: rtl/halfword_store_buffer_sb_fifo.sv
// -----------------------------------------------------------------------------
// halfword_store_buffer_sb_fifo
// Synchronous FIFO of store entries {word address, data, halfword enables}.
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_push, i_push_*      append a new entry at the tail
//   i_pop                 drop the head entry
//   i_tail_wr, i_tail_*   overwrite data/enables of the current tail (merge)
//   o_head_*              head entry contents
//   o_tail_*              tail entry contents (most recently written)
//   o_count               occupied entries
// i_push and i_tail_wr are never asserted together by the top level.
// -----------------------------------------------------------------------------
module halfword_store_buffer_sb_fifo
  import halfword_store_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WAW   = 30
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_push,
  input  logic [WAW-1:0]             i_push_addr,
  input  logic [DATA_W-1:0]          i_push_data,
  input  logic [EN_W-1:0]            i_push_en,
  input  logic                       i_pop,
  input  logic                       i_tail_wr,
  input  logic [DATA_W-1:0]          i_tail_data,
  input  logic [EN_W-1:0]            i_tail_en,
  output logic [WAW-1:0]             o_head_addr,
  output logic [DATA_W-1:0]          o_head_data,
  output logic [EN_W-1:0]            o_head_en,
  output logic [WAW-1:0]             o_tail_addr,
  output logic [DATA_W-1:0]          o_tail_data,
  output logic [EN_W-1:0]            o_tail_en,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WAW-1:0]    r_addr [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [EN_W-1:0]   r_en   [DEPTH];
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic [PW-1:0]     w_tail_idx;

  // Tail is the slot written last; pointers wrap naturally at DEPTH.
  assign w_tail_idx  = r_wr_ptr - PW'(1);
  assign o_head_addr = r_addr[r_rd_ptr];
  assign o_head_data = r_data[r_rd_ptr];
  assign o_head_en   = r_en[r_rd_ptr];
  assign o_tail_addr = r_addr[w_tail_idx];
  assign o_tail_data = r_data[w_tail_idx];
  assign o_tail_en   = r_en[w_tail_idx];
  assign o_count     = r_count;

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage: new entries at the write pointer, merges into the tail slot.
  always_ff @(posedge i_clk) begin
    if (i_push) begin
      r_addr[r_wr_ptr] <= i_push_addr;
      r_data[r_wr_ptr] <= i_push_data;
      r_en[r_wr_ptr]   <= i_push_en;
    end else if (i_tail_wr) begin
      r_data[w_tail_idx] <= i_tail_data;
      r_en[w_tail_idx]   <= i_tail_en;
    end
  end

endmodule

// File: rtl/halfword_store_buffer.sv
// -----------------------------------------------------------------------------
// halfword_store_buffer
// Queues replicated halfword stores and drains them, one at a time, to the
// data-memory write port with a req/ack handshake.
// Ports:
//   i_clk, i_rst                     clock, synchronous active-high reset
//   i_st_valid / o_st_ready          store handshake (ready = not full)
//   i_st_addr, i_st_data, i_st_en    byte address, replicated data, halfword enables
//   o_mem_req/addr/wdata/be          registered write request, held until ack
//   i_mem_ack                        one-cycle completion pulse
//   o_sb_empty                       nothing queued and nothing in flight
//   o_sb_count                       occupied entries including the in-flight one
// Configuration macro: STORE_MERGE_EN -- when defined, a store to the same
// word as the tail entry merges into it instead of allocating a new entry.
// -----------------------------------------------------------------------------
module halfword_store_buffer
  import halfword_store_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_st_valid,
  output logic                   o_st_ready,
  input  logic [AW-1:0]          i_st_addr,
  input  logic [31:0]            i_st_data,
  input  logic [1:0]             i_st_en,
  output logic                   o_mem_req,
  output logic [AW-1:0]          o_mem_addr,
  output logic [31:0]            o_mem_wdata,
  output logic [3:0]             o_mem_be,
  input  logic                   i_mem_ack,
  output logic                   o_sb_empty,
  output logic [$clog2(DEPTH):0] o_sb_count
);

  localparam int CW  = $clog2(DEPTH) + 1;
  localparam int WAW = AW - 2;

  sb_state_e         r_state;
  logic              r_mem_req;
  logic [AW-1:0]     r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [BE_W-1:0]   r_mem_be;

  logic [WAW-1:0]    w_head_addr;
  logic [DATA_W-1:0] w_head_data;
  logic [EN_W-1:0]   w_head_en;
  logic [WAW-1:0]    w_tail_addr;
  logic [DATA_W-1:0] w_tail_data;
  logic [EN_W-1:0]   w_tail_en;
  logic [CW-1:0]     w_count;

  logic              w_accept;
  logic              w_nonnull;
  logic              w_addr_match;
  logic              w_merge;
  logic              w_push;
  logic              w_tail_wr;
  logic              w_pop;
  logic [DATA_W-1:0] w_merge_data;
  logic [EN_W-1:0]   w_merge_en;
  logic              w_addr_lo_unused;

  // Stores are word aligned; the byte offset carries no information here.
  assign w_addr_lo_unused = ^i_st_addr[1:0];

  assign o_st_ready   = (w_count != CW'(DEPTH));
  assign w_accept     = i_st_valid & o_st_ready;
  assign w_nonnull    = (i_st_en != 2'b00);
  assign w_addr_match = (i_st_addr[AW-1:2] == w_tail_addr);
  assign w_merge_data = merge_halves(w_tail_data, i_st_data, i_st_en);
  assign w_merge_en   = w_tail_en | i_st_en;

`ifdef STORE_MERGE_EN
  // With a single entry the tail is the head, which is either in flight (REQ)
  // or being loaded into the write-port registers this very edge (IDLE), so
  // only a second-or-later entry may absorb a merge.
  assign w_merge = (w_count >= CW'(2)) & w_addr_match;
`else
  logic w_match_unused;
  assign w_match_unused = w_addr_match;
  assign w_merge        = 1'b0;
`endif

  // A null store (no halfword enabled) is accepted but leaves no trace.
  assign w_push    = w_accept & w_nonnull & ~w_merge;
  assign w_tail_wr = w_accept & w_nonnull & w_merge;
  assign w_pop     = (r_state == SB_REQ) & i_mem_ack;

  halfword_store_buffer_sb_fifo #(
    .DEPTH (DEPTH),
    .WAW   (WAW)
  ) u_fifo (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_push      (w_push),
    .i_push_addr (i_st_addr[AW-1:2]),
    .i_push_data (i_st_data),
    .i_push_en   (i_st_en),
    .i_pop       (w_pop),
    .i_tail_wr   (w_tail_wr),
    .i_tail_data (w_merge_data),
    .i_tail_en   (w_merge_en),
    .o_head_addr (w_head_addr),
    .o_head_data (w_head_data),
    .o_head_en   (w_head_en),
    .o_tail_addr (w_tail_addr),
    .o_tail_data (w_tail_data),
    .o_tail_en   (w_tail_en),
    .o_count     (w_count)
  );

  // Issue FSM: load the head into the write-port registers, hold until ack.
  // The head is popped on ack; the IDLE cycle that follows is the gap between
  // consecutive requests.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= SB_IDLE;
      r_mem_req   <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_be    <= '0;
    end else begin
      case (r_state)
        SB_IDLE: begin
          if (w_count != '0) begin
            r_mem_req   <= 1'b1;
            r_mem_addr  <= {w_head_addr, 2'b00};
            r_mem_wdata <= w_head_data;
            r_mem_be    <= expand_be(w_head_en);
            r_state     <= SB_REQ;
          end
        end
        SB_REQ: begin
          if (i_mem_ack) begin
            r_mem_req <= 1'b0;
            r_state   <= SB_IDLE;
          end
        end
        default: begin
          r_mem_req <= 1'b0;
          r_state   <= SB_IDLE;
        end
      endcase
    end
  end

  assign o_mem_req   = r_mem_req;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_mem_be    = r_mem_be;
  assign o_sb_count  = w_count;
  assign o_sb_empty  = (w_count == '0) & ~r_mem_req;

endmodule
